uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - Serial receiver for 8N1 frames: the downstream partner of the team's UART transmitter.
// - Consumes the serial line, synchronises it and checks the start and stop bits.
// - Delivers each byte on a parallel bus with a 1-cycle valid strobe; a bad stop bit gives a 1-cycle error strobe.
// - Default timing is 115200 baud at 50 MHz (434 clk/bit), matching the transmitter's default rate.
// PARAMETERS
// - BAUD_DIV  434  clocks per bit; legal range 4..8191; 13-bit counter (5208/2604/1302/868/434 = 9600..115200)
// PORTS
// - clk_i          in   1  system clock (50 MHz nominal)
// - rst_i          in   1  asynchronous, active-high reset
// - uart_rx_i      in   1  serial line, idle high, asynchronous to clk_i
// - rx_data_o      out  8  last good byte, LSB received first; holds until the next good frame
// - rx_valid_o     out  1  1-cycle pulse: rx_data_o updated this cycle
// - rx_frame_err_o out  1  1-cycle pulse: stop bit sampled low, frame discarded
// - rx_busy_o      out  1  high whenever state != IDLE
// BEHAVIOUR
// - Reset state: sync flops=1; state=IDLE; cnt=0; bit_idx=0; shift=0.
// - Reset outputs: rx_data_o=0, rx_valid_o=0, rx_frame_err_o=0, rx_busy_o=0.
// - Reset mid-frame aborts the frame immediately; no strobe is produced.
// - Input path: 2-flop synchroniser; rx_s is the 2nd-flop output. All decisions use rx_s only.
// - Counter: cnt counts 0..BAUD_DIV-1. HALF = BAUD_DIV/2 - 1 (integer division).
// - FSM: IDLE, START, DATA, STOP, BREAK.
// - IDLE: on rx_s==0, go to START with cnt=0.
// - START: cnt++. When cnt==HALF:
//   - rx_s==0: go to DATA, cnt=0, bit_idx=0.
//   - rx_s==1: treat as a glitch, return to IDLE with no strobe.
// - DATA: cnt++. When cnt==BAUD_DIV-1:
//   - shift <= {rx_s, shift[7:1]}, cnt=0.
//   - bit_idx==7: go to STOP; otherwise bit_idx++.
//   - Each sample therefore falls mid-bit.
// - STOP: cnt++. When cnt==BAUD_DIV-1:
//   - rx_s==1: rx_data_o<=shift, rx_valid_o=1 for the next cycle, go to IDLE.
//   - rx_s==0: rx_frame_err_o=1 for the next cycle, rx_data_o unchanged, go to BREAK.
// - BREAK: wait for rx_s==1, then go to IDLE. A held-low line never retriggers START.
// - Strobes are registered. rx_valid_o and rx_frame_err_o are mutually exclusive and never high 2 cycles in a row.
// - Latency: rx_valid_o rises 2 + 1 + (HALF+1) + 9*BAUD_DIV clocks after the uart_rx_i falling edge.
//   - 2 synchroniser, 1 IDLE detect, start half-bit, 8 data bits + stop bit.
//   - With BAUD_DIV=434 this is 3+217+3906 = 4126 clocks.
// - Back-to-back frames: a start edge is accepted the first cycle after returning to IDLE.
//   - The transmitter's full-bit stop period leaves about half a bit of margin.
// - Tolerance: correct reception for a transmitter bit period within +/-3% of BAUD_DIV.
// - rx_busy_o is combinational from state: high from the cycle after the start edge is detected until IDLE is re-entered.
// STRUCTURE
// - uart_pkg: FSM state typedef (IDLE..BREAK, 3-bit encoding) and BAUD_DIV_* constants for 9600..115200 at 50 MHz.
// - Sub-module sync_2ff: parameterised reset value (1 here), async active-high reset. Reusable for other async inputs.
// - Counter, FSM, shift register and output registers all live in uart_rx.
// TESTING
// - Reset checks:
//   - rst_i high, line idle -> all outputs 0, rx_busy_o=0.
//   - Assert rst_i mid-DATA -> busy drops at once; no strobe afterwards; next frame received correctly.
// - Frame 0xA5 at 434 clk/bit -> one rx_valid_o pulse, rx_data_o=8'hA5, exactly 4126 clks after the start edge; rx_frame_err_o stays 0.
// - Bytes 0x00, 0xFF, 0x55 sent back-to-back, 1 stop bit each -> three valid pulses; data 00, FF, 55 in order.
// - Low glitch of 100 clks on an idle line -> returns to IDLE near cnt==HALF; no strobes; busy pulse of about 218 clks.
// - Frame 0x3C with the stop bit forced low and the line then held low 5000 clks:
//   - one rx_frame_err_o pulse; rx_data_o keeps its prior value; no new frame while low.
//   - After the line goes high, frame 0x81 is received correctly.
// - BAUD_DIV=5208: frame 0x6E sent with the bit period at 5052 (-3%) and at 5364 (+3%) -> rx_data_o=8'h6E, no error, in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver FSM encoding and the standard baud divisors for a 50 MHz clock.
package uart_pkg;

    localparam int CNT_W = 13;

    // Clocks per bit at 50 MHz.
    localparam int BAUD_DIV_9600   = 5208;
    localparam int BAUD_DIV_19200  = 2604;
    localparam int BAUD_DIV_38400  = 1302;
    localparam int BAUD_DIV_57600  = 868;
    localparam int BAUD_DIV_115200 = 434;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // Counter value at which the start bit is re-checked, about mid-bit.
    function automatic int half_count(input int baud_div);
        return baud_div / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: received byte, strobes, busy and FSM state.
// rx_valid_o / rx_frame_err_o are single-cycle strobes with no back-pressure: the consumer captures on the strobe.
interface uart_rx_if;
    import uart_pkg::*;

    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_frame_err_o;
    logic        rx_busy_o;
    uart_state_t dbg_state;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output rx_frame_err_o,
        output rx_busy_o,
        output dbg_state
    );

    modport slave (
        input rx_data_o,
        input rx_valid_o,
        input rx_frame_err_o,
        input rx_busy_o,
        input dbg_state
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so an idle-high line does not look like an edge out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, eight mid-bit data samples, stop check.
// A low stop bit raises a frame error and the receiver then waits for the line to return high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_115200
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     uart_rx_i,
    uart_rx_if.master rx_if
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(half_count(BAUD_DIV));

    logic             rx_s;
    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             err_q;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (uart_rx_i),
        .q     (rx_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is gone by mid-bit was only a glitch.
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line is released so a long low level is not a new start bit.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_if.rx_data_o      = data_q;
    assign rx_if.rx_valid_o     = valid_q;
    assign rx_if.rx_frame_err_o = err_q;
    assign rx_if.rx_busy_o      = (state != ST_IDLE);
    assign rx_if.dbg_state      = state;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one receiver at 434 clk/bit for the main sequence,
// two at 5208 clk/bit fed at -3% and +3% bit periods in parallel.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] line;
    int         cyc;
    int         checks;
    int         passes;
    logic [10:0] obs [3];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // ---------------- DUTs and monitors ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV = (g == 0) ? BAUD_DIV_115200 : BAUD_DIV_9600;

        uart_rx_if rif ();

        uart_rx #(.BAUD_DIV(DIV)) dut (
            .clk_i     (clk),
            .rst_i     (rst[g]),
            .uart_rx_i (line[g]),
            .rx_if     (rif)
        );

        assign obs[g] = {rif.rx_busy_o, rif.rx_frame_err_o, rif.rx_valid_o, rif.rx_data_o};

        logic [8:0] exp_q[$];
        logic       prev_strobe = 1'b0;
        int         last_valid_cyc = 0;

        always @(negedge clk) begin
            logic       strobe;
            logic [8:0] exp;
            strobe = rif.rx_valid_o | rif.rx_frame_err_o;
            if (!rst[g] && strobe) begin
                check($sformatf("strobe_excl_%0d", g), 32'(rif.rx_valid_o & rif.rx_frame_err_o), 0);
                check($sformatf("strobe_gap_%0d", g), 32'(prev_strobe), 0);
                check($sformatf("expected_strobe_%0d", g), 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check($sformatf("rx_out_%0d", g), 32'({rif.rx_frame_err_o, rif.rx_data_o}), 32'(exp));
                end
                if (rif.rx_valid_o) last_valid_cyc <= cyc;
            end
            prev_strobe <= strobe & !rst[g];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int g, input logic [8:0] v);
        case (g)
            0: g_dut[0].exp_q.push_back(v);
            1: g_dut[1].exp_q.push_back(v);
            default: g_dut[2].exp_q.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int g);
        case (g)
            0: return g_dut[0].exp_q.size();
            1: return g_dut[1].exp_q.size();
            default: return g_dut[2].exp_q.size();
        endcase
    endfunction

    // Drives start, 8 data bits LSB first, then the stop bit, which is left on the line.
    task automatic send_frame(input int g, input logic [7:0] b, input int period,
                              input logic stop_bit, output int t0);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            line[g] = bits[i];
            repeat (period) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input int g, input int budget);
        for (int i = 0; i < budget && q_size(g) != 0; i++) @(negedge clk);
        check($sformatf("drain_%0d", g), 32'(q_size(g)), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] last_good;

    initial begin
        int t0;
        int busy_cnt;
        checks = 0;
        passes = 0;
        last_good = 8'h00;
        rst  = 3'b111;
        line = 3'b111;
        repeat (5) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_data_%0d", g), 32'(obs[g][7:0]), 0);
            check($sformatf("reset_valid_%0d", g), 32'(obs[g][8]), 0);
            check($sformatf("reset_err_%0d", g), 32'(obs[g][9]), 0);
            check($sformatf("reset_busy_%0d", g), 32'(obs[g][10]), 0);
        end
        rst = 3'b000;
        repeat (3) @(negedge clk);

        fork
            begin : seq_main
                // Abort a frame mid-DATA with reset.
                line[0] = 1'b0;
                repeat (1000) @(negedge clk);
                check("busy_mid_data", 32'(obs[0][10]), 1);
                rst[0] = 1'b1;
                #1;
                check("rst_mid_busy", 32'(obs[0][10]), 0);
                check("rst_mid_valid", 32'(obs[0][8]), 0);
                @(negedge clk);
                line[0] = 1'b1;
                repeat (3) @(negedge clk);
                rst[0] = 1'b0;
                repeat (4500) @(negedge clk);
                check("after_abort_busy", 32'(obs[0][10]), 0);

                // 0xA5 with latency check.
                push_exp(0, {1'b0, 8'hA5});
                last_good = 8'hA5;
                send_frame(0, 8'hA5, 434, 1'b1, t0);
                wait_drain(0, 2000);
                check("latency_a5", 32'(g_dut[0].last_valid_cyc - t0), 4126);

                // Back-to-back frames with a single stop bit.
                push_exp(0, {1'b0, 8'h00});
                push_exp(0, {1'b0, 8'hFF});
                push_exp(0, {1'b0, 8'h55});
                last_good = 8'h55;
                send_frame(0, 8'h00, 434, 1'b1, t0);
                send_frame(0, 8'hFF, 434, 1'b1, t0);
                send_frame(0, 8'h55, 434, 1'b1, t0);
                wait_drain(0, 2000);

                // 100-clock low glitch on an idle line.
                busy_cnt = 0;
                line[0] = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    if (i == 100) line[0] = 1'b1;
                    @(negedge clk);
                    if (obs[0][10]) busy_cnt++;
                end
                check("glitch_busy_len", 32'(busy_cnt), 217);
                check("glitch_idle", 32'(obs[0][10]), 0);

                // Low stop bit, line then held low.
                push_exp(0, {1'b1, last_good});
                send_frame(0, 8'h3C, 434, 1'b0, t0);
                repeat (5000) @(negedge clk);
                check("break_busy", 32'(obs[0][10]), 1);
                check("break_data_kept", 32'(obs[0][7:0]), 32'(last_good));
                check("break_drain", 32'(q_size(0)), 0);
                line[0] = 1'b1;
                repeat (5) @(negedge clk);
                check("break_released", 32'(obs[0][10]), 0);
                push_exp(0, {1'b0, 8'h81});
                last_good = 8'h81;
                send_frame(0, 8'h81, 434, 1'b1, t0);
                wait_drain(0, 2000);
                check("final_data_0", 32'(obs[0][7:0]), 32'(last_good));
            end
            begin : seq_slow
                push_exp(1, {1'b0, 8'h6E});
                send_frame(1, 8'h6E, 5052, 1'b1, t0);
                wait_drain(1, 6000);
                check("slow_data", 32'(obs[1][7:0]), 32'h6E);
            end
            begin : seq_fast
                push_exp(2, {1'b0, 8'h6E});
                send_frame(2, 8'h6E, 5364, 1'b1, t0);
                wait_drain(2, 6000);
                check("fast_data", 32'(obs[2][7:0]), 32'h6E);
            end
        join

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
